// File: rtl/troco_dispenser.sv
// Change-ejection stage: greedy largest-first coin dispenser with per-denomination
// stock tracking, completion strobe and error reporting of the unpaid remainder.
module troco_dispenser #(
  parameter int VAL_W      = 6,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [VAL_W-1:0] troco_valor,
  input  logic             troco_valido,
  input  logic             recarga,
  output logic [2:0]       moeda_sel,
  output logic             moeda_pulso,
  output logic             ocupado,
  output logic             concluido,
  output logic             erro_troco,
  output logic [VAL_W-1:0] troco_restante
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE,
    S_ERRO
  } state_t;

  state_t             r_state;
  logic [VAL_W-1:0]   r_rem;
  logic [STOCK_W-1:0] r_stock [0:4];
  logic [2:0]         r_idx;
  logic [GAP_W-1:0]   r_gap;

  logic               w_found;
  logic [2:0]         w_idx;

  // Denomination values in units of R$0.05, index 0 is the largest coin.
  function automatic logic [VAL_W-1:0] coin_val(input logic [2:0] idx);
    case (idx)
      3'd0:    coin_val = VAL_W'(20);
      3'd1:    coin_val = VAL_W'(10);
      3'd2:    coin_val = VAL_W'(5);
      3'd3:    coin_val = VAL_W'(2);
      default: coin_val = VAL_W'(1);
    endcase
  endfunction

  // Lowest eligible index wins, which is the largest coin that still fits.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (!w_found && (coin_val(3'(i)) <= r_rem) && (r_stock[i] != '0)) begin
        w_found = 1'b1;
        w_idx   = 3'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_rem          <= '0;
      r_idx          <= '0;
      r_gap          <= '0;
      moeda_sel      <= '0;
      moeda_pulso    <= 1'b0;
      ocupado        <= 1'b0;
      concluido      <= 1'b0;
      erro_troco     <= 1'b0;
      troco_restante <= '0;
      for (int unsigned i = 0; i < 5; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      moeda_pulso <= 1'b0;
      concluido   <= 1'b0;
      erro_troco  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (recarga) begin
            for (int unsigned i = 0; i < 5; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
          end
          if (troco_valido) begin
            r_rem          <= troco_valor;
            troco_restante <= '0;
            ocupado        <= 1'b1;
            r_state        <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (r_rem == '0) begin
            r_state <= S_DONE;
          end else if (w_found) begin
            r_idx   <= w_idx;
            r_state <= S_PULSE;
          end else begin
            r_state <= S_ERRO;
          end
        end
        S_PULSE: begin
          moeda_pulso      <= 1'b1;
          moeda_sel        <= r_idx;
          r_rem            <= r_rem - coin_val(r_idx);
          r_stock[r_idx]   <= r_stock[r_idx] - STOCK_W'(1);
          r_gap            <= '0;
          r_state          <= S_GAP;
        end
        S_GAP: begin
          if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
            r_state <= S_SELECT;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        S_DONE: begin
          concluido      <= 1'b1;
          troco_restante <= '0;
          ocupado        <= 1'b0;
          r_state        <= S_IDLE;
        end
        S_ERRO: begin
          erro_troco     <= 1'b1;
          troco_restante <= r_rem;
          ocupado        <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: begin
          ocupado <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_troco_dispenser.sv
// Bench for troco_dispenser: directed scenarios plus random transactions checked
// against a greedy change model with per-denomination stock bookkeeping.
module tb_troco_dispenser;

  localparam int G = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] valor   [2];
  logic       valido  [2];
  logic       recarga [2];
  logic [2:0] sel     [2];
  logic       pulso   [2];
  logic       ocup    [2];
  logic       conc    [2];
  logic       erro    [2];
  logic [5:0] rest    [2];

  int vectors = 0;
  int fails   = 0;
  int stk [2][5];
  int init_s [2] = '{8, 1};
  int coin   [5] = '{20, 10, 5, 2, 1};

  always #5 clock = ~clock;

  troco_dispenser #(.VAL_W(6), .STOCK_W(4), .INIT_STOCK(8), .GAP_CYCLES(G)) dut0 (
    .clock(clock), .reset(reset), .troco_valor(valor[0]), .troco_valido(valido[0]),
    .recarga(recarga[0]), .moeda_sel(sel[0]), .moeda_pulso(pulso[0]), .ocupado(ocup[0]),
    .concluido(conc[0]), .erro_troco(erro[0]), .troco_restante(rest[0])
  );

  troco_dispenser #(.VAL_W(6), .STOCK_W(4), .INIT_STOCK(1), .GAP_CYCLES(G)) dut1 (
    .clock(clock), .reset(reset), .troco_valor(valor[1]), .troco_valido(valido[1]),
    .recarga(recarga[1]), .moeda_sel(sel[1]), .moeda_pulso(pulso[1]), .ocupado(ocup[1]),
    .concluido(conc[1]), .erro_troco(erro[1]), .troco_restante(rest[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic refill(input int inst);
    for (int d = 0; d < 5; d++) stk[inst][d] = init_s[inst];
  endtask

  task automatic chk_idle_outputs(input int inst, input string tag);
    chk({tag, "_sel"},   32'(sel[inst]),   0);
    chk({tag, "_pulso"}, 32'(pulso[inst]), 0);
    chk({tag, "_ocup"},  32'(ocup[inst]),  0);
    chk({tag, "_conc"},  32'(conc[inst]),  0);
    chk({tag, "_erro"},  32'(erro[inst]),  0);
    chk({tag, "_rest"},  32'(rest[inst]),  0);
  endtask

  // One transaction; inj>0 fires a stray strobe+recarga k cycles into it.
  task automatic txn(input int inst, input int amount, input bit rec, input int inj);
    int  exp_sel [$];
    int  rem, nexp, done_k, k, npulse, ocnt;
    bit  fin;
    if (rec) refill(inst);
    rem = amount;
    for (int d = 0; d < 5; d++) begin
      while (rem >= coin[d] && stk[inst][d] > 0) begin
        exp_sel.push_back(d);
        rem -= coin[d];
        stk[inst][d]--;
      end
    end
    nexp   = exp_sel.size();
    done_k = (nexp == 0) ? 2 : 2 + (nexp - 1) * (G + 2) + G + 2;

    @(negedge clock);
    valor[inst]   = 6'(amount);
    valido[inst]  = 1'b1;
    recarga[inst] = rec;
    @(negedge clock);
    k = 0; npulse = 0; ocnt = 0; fin = 1'b0;
    while (!fin && k < 300) begin
      if (ocup[inst]) ocnt++;
      if (pulso[1 - inst]) chk("stray_pulse_other", 1, 0);
      if (pulso[inst]) begin
        if (npulse < nexp) begin
          chk("pulse_sel", 32'(sel[inst]), 32'(exp_sel[npulse]));
          chk("pulse_cycle", 32'(k), 32'(2 + npulse * (G + 2)));
        end else begin
          chk("extra_pulse", 32'(npulse + 1), 32'(nexp));
        end
        npulse++;
      end
      if (conc[inst] || erro[inst]) begin
        fin = 1'b1;
        chk("end_cycle", 32'(k), 32'(done_k));
        chk("concluido", 32'(conc[inst]), 32'(rem == 0));
        chk("erro_troco", 32'(erro[inst]), 32'(rem != 0));
        chk("restante", 32'(rest[inst]), 32'(rem));
      end
      if (inj > 0 && k == inj) begin
        valido[inst]  = 1'b1;
        valor[inst]   = 6'd5;
        recarga[inst] = 1'b1;
      end else begin
        valido[inst]  = 1'b0;
        recarga[inst] = 1'b0;
      end
      @(negedge clock);
      k++;
    end
    valido[inst]  = 1'b0;
    recarga[inst] = 1'b0;
    chk("done_seen", 32'(fin), 1);
    chk("pulse_count", 32'(npulse), 32'(nexp));
    chk("ocupado_cycles", 32'(ocnt), 32'(done_k));
    chk("concluido_1cyc", 32'(conc[inst]), 0);
    chk("erro_1cyc", 32'(erro[inst]), 0);
    chk("restante_hold", 32'(rest[inst]), 32'(rem));
    chk("ocupado_idle", 32'(ocup[inst]), 0);
  endtask

  task automatic do_recarga(input int inst);
    @(negedge clock);
    recarga[inst] = 1'b1;
    @(negedge clock);
    recarga[inst] = 1'b0;
    refill(inst);
  endtask

  initial begin
    int  cnt, amt, waitk;
    bit  seen;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valor[i] = '0; valido[i] = 1'b0; recarga[i] = 1'b0;
      refill(i);
    end
    repeat (3) @(negedge clock);
    chk_idle_outputs(0, "reset0");
    chk_idle_outputs(1, "reset1");
    reset = 1'b1;
    @(negedge clock);

    txn(0, 17, 1'b0, 0);
    txn(0, 40, 1'b0, 0);
    txn(1, 40, 1'b0, 0);
    do_recarga(1);
    txn(1, 2, 1'b0, 0);
    txn(1, 2, 1'b1, 0);
    txn(0, 0, 1'b0, 0);
    txn(0, 17, 1'b0, 3);

    // Reset asserted in the gap after the first coin of a 40 transaction.
    @(negedge clock);
    valor[0] = 6'd40; valido[0] = 1'b1;
    @(negedge clock);
    valido[0] = 1'b0;
    seen = 1'b0; waitk = 0;
    while (!seen && waitk < 20) begin
      @(negedge clock);
      seen = pulso[0];
      waitk++;
    end
    chk("first_pulse_seen", 32'(seen), 1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_idle_outputs(0, "abort");
    refill(0);
    refill(1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (pulso[0] || pulso[1] || ocup[0]) cnt++;
    end
    chk("post_reset_activity", 32'(cnt), 0);
    txn(0, 40, 1'b0, 0);
    txn(1, 40, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      amt = int'($urandom_range(0, 63));
      txn(0, amt, ($urandom_range(0, 3) == 0), (amt > 0 && $urandom_range(0, 2) == 0) ? 1 : 0);
    end
    for (int n = 0; n < 10; n++) begin
      amt = int'($urandom_range(0, 63));
      txn(1, amt, ($urandom_range(0, 1) == 0), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
